// File: rtl/pipe_ctrl_tracker_if.sv
// D-stage inputs and per-stage tracked state shared between the pipeline
// control tracker and the datapath around it.
interface pipe_ctrl_tracker_if #(
  parameter int STAGES = 3
);
  logic [31:0]          instr_d;
  logic [31:0]          pc_d;
  logic                 valid_d;
  logic [4:0]           exc_d;
  logic                 md_busy;
  logic                 flush;
  logic                 stall_d;
  logic [STAGES-1:0]    valid_p;
  logic [32*STAGES-1:0] instr_p;
  logic [32*STAGES-1:0] pc_p;
  logic [5*STAGES-1:0]  exc_p;
  logic [STAGES-1:0]    bd_p;
  logic [5*STAGES-1:0]  waddr_p;
  logic [2*STAGES-1:0]  tnew_p;

  modport master (
    output instr_d, pc_d, valid_d, exc_d, md_busy, flush,
    input  stall_d, valid_p, instr_p, pc_p, exc_p, bd_p, waddr_p, tnew_p
  );

  modport slave (
    input  instr_d, pc_d, valid_d, exc_d, md_busy, flush,
    output stall_d, valid_p, instr_p, pc_p, exc_p, bd_p, waddr_p, tnew_p
  );
endinterface

// File: rtl/pipe_ctrl_tracker.sv
// Classifies the D-stage instruction, derives the Tuse/Tnew stall and carries
// instr/PC/ExcCode/BD/waddr/Tnew through STAGES registered stages.
module pipe_ctrl_tracker #(
  parameter int          STAGES   = 3,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter bit          CP0_EN   = 1'b1,
  parameter logic [4:0]  RI_CODE  = 5'd10
) (
  input logic                clk,
  input logic                reset,
  pipe_ctrl_tracker_if.slave bus
);

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd;

  assign op = bus.instr_d[31:26];
  assign rs = bus.instr_d[25:21];
  assign rt = bus.instr_d[20:16];
  assign rd = bus.instr_d[15:11];
  assign fn = bus.instr_d[5:0];

  logic       dec_known, dec_use_rs, dec_use_rt, dec_is_md, dec_is_eret, dec_is_bj;
  logic [1:0] dec_tuse_rs, dec_tuse_rt, dec_tnew;
  logic [4:0] dec_dest;

  always_comb begin
    dec_known   = 1'b0;
    dec_use_rs  = 1'b0;
    dec_use_rt  = 1'b0;
    dec_tuse_rs = 2'd0;
    dec_tuse_rt = 2'd0;
    dec_tnew    = 2'd0;
    dec_dest    = 5'd0;
    dec_is_md   = 1'b0;
    dec_is_eret = 1'b0;
    dec_is_bj   = 1'b0;
    case (op)
      6'h00: begin
        case (fn)
          6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            dec_known   = 1'b1;
            dec_use_rs  = 1'b1;
            dec_use_rt  = 1'b1;
            dec_tuse_rs = 2'd1;
            dec_tuse_rt = 2'd1;
            dec_tnew    = 2'd1;
            dec_dest    = rd;
          end
          6'h00, 6'h02, 6'h03: begin
            dec_known   = 1'b1;
            dec_use_rt  = 1'b1;
            dec_tuse_rt = 2'd1;
            dec_tnew    = 2'd1;
            dec_dest    = rd;
          end
          6'h08: begin
            dec_known  = 1'b1;
            dec_use_rs = 1'b1;
            dec_is_bj  = 1'b1;
          end
          6'h09: begin
            dec_known  = 1'b1;
            dec_use_rs = 1'b1;
            dec_dest   = rd;
            dec_is_bj  = 1'b1;
          end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            dec_known   = 1'b1;
            dec_use_rs  = 1'b1;
            dec_use_rt  = 1'b1;
            dec_tuse_rs = 2'd1;
            dec_tuse_rt = 2'd1;
            dec_is_md   = 1'b1;
          end
          6'h11, 6'h13: begin
            dec_known   = 1'b1;
            dec_use_rs  = 1'b1;
            dec_tuse_rs = 2'd1;
            dec_is_md   = 1'b1;
          end
          6'h10, 6'h12: begin
            dec_known = 1'b1;
            dec_tnew  = 2'd1;
            dec_dest  = rd;
            dec_is_md = 1'b1;
          end
          default: ;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0 || rt == 5'd1) begin
          dec_known  = 1'b1;
          dec_use_rs = 1'b1;
          dec_is_bj  = 1'b1;
        end
      end
      6'h02: begin
        dec_known = 1'b1;
        dec_is_bj = 1'b1;
      end
      6'h03: begin
        dec_known = 1'b1;
        dec_dest  = 5'd31;
        dec_is_bj = 1'b1;
      end
      6'h04, 6'h05: begin
        dec_known  = 1'b1;
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
        dec_is_bj  = 1'b1;
      end
      6'h06, 6'h07: begin
        dec_known  = 1'b1;
        dec_use_rs = 1'b1;
        dec_is_bj  = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec_known   = 1'b1;
        dec_use_rs  = 1'b1;
        dec_tuse_rs = 2'd1;
        dec_tnew    = 2'd1;
        dec_dest    = rt;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec_known   = 1'b1;
        dec_use_rs  = 1'b1;
        dec_tuse_rs = 2'd1;
        dec_tnew    = 2'd2;
        dec_dest    = rt;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec_known   = 1'b1;
        dec_use_rs  = 1'b1;
        dec_use_rt  = 1'b1;
        dec_tuse_rs = 2'd1;
        dec_tuse_rt = 2'd2;
      end
      6'h10: begin
        if (bus.instr_d == 32'h4200_0018) begin
          dec_known   = 1'b1;
          dec_is_eret = 1'b1;
        end else if (rs == 5'd0) begin
          dec_known = 1'b1;
          dec_tnew  = 2'd2;
          dec_dest  = rt;
        end else if (rs == 5'd4) begin
          dec_known   = 1'b1;
          dec_use_rt  = 1'b1;
          dec_tuse_rt = 2'd2;
        end
      end
      default: ;
    endcase
  end

  logic [STAGES-1:0] valid_q, bd_q;
  logic [31:0]       instr_q [STAGES];
  logic [31:0]       pc_q    [STAGES];
  logic [4:0]        exc_q   [STAGES];
  logic [4:0]        waddr_q [STAGES];
  logic [1:0]        tnew_q  [STAGES];
  logic              bd_trk_q, bd_trk_d;

  logic haz_rs, haz_rt;

  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (valid_q[k] && (waddr_q[k] == rs) && (tnew_q[k] > dec_tuse_rs)) haz_rs = 1'b1;
      if (valid_q[k] && (waddr_q[k] == rt) && (tnew_q[k] > dec_tuse_rt)) haz_rt = 1'b1;
    end
  end

  // mult/div still in E has not yet raised md_busy, and an EPC write must land before eret reads it
  logic md_in_e, epc_wr_0, epc_wr_1, stall_cause, stall, take;

  assign md_in_e  = valid_q[0] && (instr_q[0][31:26] == 6'h00) && (instr_q[0][5:2] == 4'b0110);
  assign epc_wr_0 = valid_q[0] && (instr_q[0][31:21] == {6'h10, 5'd4}) && (instr_q[0][15:11] == 5'd14);
  assign epc_wr_1 = valid_q[1] && (instr_q[1][31:21] == {6'h10, 5'd4}) && (instr_q[1][15:11] == 5'd14);

  assign stall_cause = (dec_use_rs && (rs != 5'd0) && haz_rs) ||
                       (dec_use_rt && (rt != 5'd0) && haz_rt) ||
                       (dec_is_md && (bus.md_busy || md_in_e)) ||
                       (dec_is_eret && (epc_wr_0 || epc_wr_1));

  assign stall = bus.valid_d && stall_cause && !bus.flush;
  assign take  = bus.valid_d && !stall;

  logic [4:0] exc_new;
  logic [4:0] waddr_new;

  always_comb begin
    exc_new = bus.exc_d;
    if ((bus.exc_d == 5'd0) && !dec_known && CP0_EN) exc_new = RI_CODE;
  end

  assign waddr_new = (exc_new != 5'd0) ? 5'd0 : dec_dest;
  assign bd_trk_d  = take ? dec_is_bj : bd_trk_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      bd_q     <= '0;
      bd_trk_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        instr_q[k] <= 32'd0;
        pc_q[k]    <= RESET_PC;
        exc_q[k]   <= 5'd0;
        waddr_q[k] <= 5'd0;
        tnew_q[k]  <= 2'd0;
      end
    end else if (bus.flush) begin
      valid_q  <= '0;
      bd_q     <= '0;
      bd_trk_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        instr_q[k] <= 32'd0;
        pc_q[k]    <= 32'd0;
        exc_q[k]   <= 5'd0;
        waddr_q[k] <= 5'd0;
        tnew_q[k]  <= 2'd0;
      end
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        bd_q[k]    <= bd_q[k-1];
        instr_q[k] <= instr_q[k-1];
        pc_q[k]    <= pc_q[k-1];
        exc_q[k]   <= exc_q[k-1];
        waddr_q[k] <= waddr_q[k-1];
        tnew_q[k]  <= (tnew_q[k-1] != 2'd0) ? tnew_q[k-1] - 2'd1 : 2'd0;
      end
      // Bubbles still carry pc_d and the BD flag so EPC stays correct on them
      valid_q[0] <= take;
      bd_q[0]    <= bd_trk_q;
      pc_q[0]    <= bus.pc_d;
      instr_q[0] <= take ? bus.instr_d : 32'd0;
      exc_q[0]   <= take ? exc_new : 5'd0;
      waddr_q[0] <= take ? waddr_new : 5'd0;
      tnew_q[0]  <= take ? dec_tnew : 2'd0;
      bd_trk_q   <= bd_trk_d;
    end
  end

  logic [32*STAGES-1:0] instr_flat, pc_flat;
  logic [5*STAGES-1:0]  exc_flat, waddr_flat;
  logic [2*STAGES-1:0]  tnew_flat;

  always_comb begin
    instr_flat = '0;
    pc_flat    = '0;
    exc_flat   = '0;
    waddr_flat = '0;
    tnew_flat  = '0;
    for (int k = 0; k < STAGES; k++) begin
      instr_flat[32*k +: 32] = instr_q[k];
      pc_flat[32*k +: 32]    = pc_q[k];
      exc_flat[5*k +: 5]     = exc_q[k];
      waddr_flat[5*k +: 5]   = waddr_q[k];
      tnew_flat[2*k +: 2]    = tnew_q[k];
    end
  end

  assign bus.stall_d = stall;
  assign bus.valid_p = valid_q;
  assign bus.bd_p    = bd_q;
  assign bus.instr_p = instr_flat;
  assign bus.pc_p    = pc_flat;
  assign bus.exc_p   = exc_flat;
  assign bus.waddr_p = waddr_flat;
  assign bus.tnew_p  = tnew_flat;

endmodule
